dat_mem_arbiter: RTL and testbench

//  Shares the single-port 8x256 data memory among NREQ requesters (core load/store

---
 rtl/dat_mem_arbiter.sv | 112 +++++++++++
 tb/tb_dat_mem_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dat_mem_arbiter.sv
// Round-robin arbiter that shares a single-port data memory among NREQ requesters.
// One access per cycle. A locking owner may hold the port for a bounded burst. Read data is registered back to the winner.
module dat_mem_arbiter #(
  parameter int NREQ      = 2,
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  input  logic [NREQ-1:0]    lock,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               mem_wr_en,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_dat_in,
  input  logic [DW-1:0]      mem_dat_out
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

  logic [IW-1:0]   last_q, last_d;
  logic            locked_q, locked_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic            grant;
  logic [IW-1:0]   win;

  // A locked owner keeps the port until its burst budget runs out. After that the search rotates from last+1.
  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    int idx;
    grant = 1'b0;
    win   = last_q;
    idx   = 0;
    if (locked_q && req[last_q] && (cnt_q < CNT_MAX)) begin
      grant = 1'b1;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (int'(last_q) + k) % NREQ;
        if (!grant && req[IW'(idx)]) begin
          grant = 1'b1;
          win   = IW'(idx);
        end
      end
    end
    // Reset gates the grant at once, so a write in flight cannot commit at the reset edge.
    if (reset) grant = 1'b0;
  end

  always_comb begin
    gnt        = '0;
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    mem_dat_in = '0;
    if (grant) begin
      gnt[win]   = 1'b1;
      mem_wr_en  = we[win];
      mem_addr   = addr[int'(win)*AW +: AW];
      mem_dat_in = wdata[int'(win)*DW +: DW];
    end
  end

  always_comb begin
    last_d   = last_q;
    locked_d = 1'b0;
    cnt_d    = '0;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (grant) begin
      last_d   = win;
      locked_d = lock[win];
      if (win == last_q) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      else               cnt_d = CW'(1);
      if (!we[win]) begin
        rvalid_d[win] = 1'b1;
        rdata_d       = mem_dat_out;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q   <= LAST_RST;
      locked_q <= 1'b0;
      cnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      last_q   <= last_d;
      locked_q <= locked_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_dat_mem_arbiter.sv
// Bench for dat_mem_arbiter: the memory is modelled here, a rule-level arbitration model is checked every cycle,
// and directed scenarios carry hand-computed expectations.
module tb_dat_mem_arbiter;
  localparam int NREQ = 2, AW = 8, DW = 8, MAX_BURST = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]    req = '0, we = '0, lock = '0;
  logic [NREQ*AW-1:0] addr = '0;
  logic [NREQ*DW-1:0] wdata = '0;
  logic [NREQ-1:0]    gnt, rvalid;
  logic [DW-1:0]      rdata, mem_dat_in, mem_dat_out;
  logic               mem_wr_en;
  logic [AW-1:0]      mem_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dat_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata), .lock(lock),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_dat_in(mem_dat_in), .mem_dat_out(mem_dat_out)
  );

  function automatic logic [7:0] init_val(input int i);
    return 8'(i) ^ 8'h5A;
  endfunction

  // The memory itself: combinational read, write committed on the clock edge.
  logic [7:0] mem [256];
  assign mem_dat_out = mem[mem_addr];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (mem_wr_en) mem[mem_addr] <= mem_dat_in;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: arbitration rules in plain integers, plus a shadow copy of the memory contents.
  int         m_last = NREQ - 1;
  bit         m_locked = 1'b0;
  int         m_run = 0;
  logic [1:0] exp_rvalid = '0;
  logic [7:0] exp_rdata = '0;
  logic [7:0] ref_mem [256];

  initial for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

  function automatic int pick(input int r);
    if (m_locked && (((r >> m_last) & 1) == 1) && m_run < MAX_BURST) return m_last;
    for (int k = 1; k <= NREQ; k++)
      if (((r >> ((m_last + k) % NREQ)) & 1) == 1) return (m_last + k) % NREQ;
    return -1;
  endfunction

  always @(negedge clk) begin
    int         w;
    int         r_i;
    logic [1:0] eg;
    logic       ew;
    logic [7:0] ea, ed;
    if (reset) begin
      check("rst_gnt", gnt, 0);
      check("rst_rvalid", rvalid, 0);
      m_last = NREQ - 1;
      m_locked = 1'b0;
      m_run = 0;
      exp_rvalid = '0;
      exp_rdata = '0;
    end else begin
      r_i = int'(req);
      w = pick(r_i);
      eg = '0; ew = 1'b0; ea = '0; ed = '0;
      if (w >= 0) begin
        eg = 2'(1 << w);
        ew = we[w];
        ea = 8'(addr >> (w * AW));
        ed = 8'(wdata >> (w * DW));
      end
      check("cmp_gnt", gnt, eg);
      check("cmp_mem_wr_en", mem_wr_en, ew);
      check("cmp_mem_addr", mem_addr, ea);
      check("cmp_mem_dat_in", mem_dat_in, ed);
      check("cmp_rvalid", rvalid, exp_rvalid);
      check("cmp_rdata", rdata, exp_rdata);
      exp_rvalid = '0;
      if (w >= 0) begin
        m_run = (w == m_last) ? ((m_run < MAX_BURST) ? m_run + 1 : MAX_BURST) : 1;
        m_locked = lock[w];
        m_last = w;
        if (ew) ref_mem[ea] = ed;
        else begin
          exp_rvalid = eg;
          exp_rdata = ref_mem[ea];
        end
      end else begin
        m_locked = 1'b0;
        m_run = 0;
      end
    end
  end

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [7:0] a0, input logic [7:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] l);
    @(posedge clk);
    #1;
    req = r; we = w; addr = {a1, a0}; wdata = {d1, d0}; lock = l;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    req = '0; we = '0; lock = '0;
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [1:0] pat_lock [9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
  logic [1:0] pat_rr   [4] = '{2'b10, 2'b01, 2'b10, 2'b01};

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;

    // Two reads after reset: requester 0 first, data returned one cycle later.
    drive(2'b11, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b00);
    @(negedge clk); check("t1_gnt0", gnt, 2'b01);
    drive(2'b10, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b00);
    @(negedge clk); check("t1_gnt1", gnt, 2'b10);
    check("t1_rvalid0", rvalid, 2'b01); check("t1_rdata0", rdata, 8'h4A);
    drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
    @(negedge clk); check("t1_rvalid1", rvalid, 2'b10); check("t1_rdata1", rdata, 8'h7A);

    // Write then read-after-write of the same word.
    drive(2'b10, 2'b10, 8'h00, 8'h3C, 8'h00, 8'hA5, 2'b00);
    @(negedge clk); check("t2_wgnt", gnt, 2'b10); check("t2_wr_en", mem_wr_en, 1);
    check("t2_waddr", mem_addr, 8'h3C); check("t2_wdat", mem_dat_in, 8'hA5);
    drive(2'b01, 2'b00, 8'h3C, 8'h00, 8'h00, 8'h00, 2'b00);
    @(negedge clk); check("t2_rgnt", gnt, 2'b01); check("t2_rvalid_wr", rvalid, 2'b00);
    drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
    @(negedge clk); check("t2_rvalid", rvalid, 2'b01); check("t2_rdata", rdata, 8'hA5);

    // Idle: outputs parked, rdata holds.
    drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
    @(negedge clk); check("t6_gnt", gnt, 0); check("t6_wr_en", mem_wr_en, 0);
    check("t6_addr", mem_addr, 0); check("t6_rvalid", rvalid, 0); check("t6_rdata_hold", rdata, 8'hA5);
    check("t2_mem_word", mem[8'h3C], 8'hA5);

    // Burst lock against a competing requester, then plain alternation.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(2'b11, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00, 2'b01);
      @(negedge clk); check($sformatf("t3_lock_gnt%0d", i), gnt, pat_lock[i]);
    end
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00, 2'b00);
      @(negedge clk); check($sformatf("t3_rr_gnt%0d", i), gnt, pat_rr[i]);
    end

    // Sole locking requester keeps the port; the saturated burst yields as soon as another requests.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(2'b01, 2'b00, 8'h05, 8'h00, 8'h00, 8'h00, 2'b01);
      @(negedge clk); check($sformatf("t4_gnt%0d", i), gnt, 2'b01);
    end
    drive(2'b11, 2'b00, 8'h05, 8'h06, 8'h00, 8'h00, 2'b01);
    @(negedge clk); check("t4_yield", gnt, 2'b10);

    // Reset lands while a write is granted: grant and write enable drop at once, the word is untouched.
    drive(2'b10, 2'b10, 8'h00, 8'h77, 8'h00, 8'hEE, 2'b00);
    #2; check("t5_pre_gnt", gnt, 2'b10); check("t5_pre_wr", mem_wr_en, 1);
    reset = 1'b1;
    #1; check("t5_gnt_drop", gnt, 0); check("t5_wr_drop", mem_wr_en, 0); check("t5_rvalid", rvalid, 0);
    @(negedge clk);
    #1; req = '0; we = '0; reset = 1'b0;
    drive(2'b11, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b00);
    @(negedge clk); check("t5_first_gnt", gnt, 2'b01);
    drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
    @(negedge clk); check("t5_rdata", rdata, 8'h4A); check("t5_mem_word", mem[8'h77], 8'h2D);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
